vx_mem_obi_arbiter: RTL and testbench

//  Shares one VX memory port (the single-outstanding VX->OBI bridge) between NUM_REQ VX memory requesters (e.g. icache/dcache fill ports).

---
 rtl/vx_mem_arb_pkg.sv | 15 +
 rtl/vx_rr_pick.sv | 32 +++
 rtl/vx_mem_obi_arbiter.sv | 151 +++++++++++++++
 tb/tb_vx_mem_obi_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_arb_pkg.sv
// rtl/vx_mem_arb_pkg.sv - shared types and widths for the VX memory port arbiter
package vx_mem_arb_pkg;

  // Arbiter FSM: grant in IDLE, present to downstream in SEND, route read data in WAIT_RSP
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

endpackage

// File: rtl/vx_rr_pick.sv
// rtl/vx_rr_pick.sv - combinational round-robin picker starting at a priority pointer
module vx_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] grant_o
);

  int pos;

  // Scan from ptr_i upward with wrap; the first asserted request wins
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    pos     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        idx_o        = IDX_W'(pos);
        grant_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_mem_obi_arbiter.sv
// rtl/vx_mem_obi_arbiter.sv - round-robin sharing of one single-outstanding VX memory port
module vx_mem_obi_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int TAG_WIDTH_BIT = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0]                 req_rw_i,
  input  logic [NUM_REQ*BE_W-1:0]            req_byteen_i,
  input  logic [NUM_REQ*ADDR_W-1:0]          req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]          req_data_i,
  input  logic [NUM_REQ*TAG_WIDTH_BIT-1:0]   req_tag_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [DATA_W-1:0]                  rsp_data_o,
  output logic [TAG_WIDTH_BIT-1:0]           rsp_tag_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic                               mem_req_valid_o,
  output logic                               mem_req_rw_o,
  output logic [BE_W-1:0]                    mem_req_byteen_o,
  output logic [ADDR_W-1:0]                  mem_req_addr_o,
  output logic [DATA_W-1:0]                  mem_req_data_o,
  output logic [TAG_WIDTH_BIT-1:0]           mem_req_tag_o,
  input  logic                               mem_req_ready_i,
  input  logic                               mem_rsp_valid_i,
  input  logic [DATA_W-1:0]                  mem_rsp_data_i,
  input  logic [TAG_WIDTH_BIT-1:0]           mem_rsp_tag_i,
  output logic                               mem_rsp_ready_o,
  output logic                               err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         prio_ptr_q, prio_ptr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic                     rw_q, rw_d;
  logic [BE_W-1:0]          byteen_q, byteen_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [TAG_WIDTH_BIT-1:0] tag_q, tag_d;
  logic                     err_q, err_d;

  logic                     pick_any;
  logic [IDX_W-1:0]         pick_idx;
  logic [NUM_REQ-1:0]       pick_grant;

  vx_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (prio_ptr_q),
    .any_o   (pick_any),
    .idx_o   (pick_idx),
    .grant_o (pick_grant)
  );

  // The downstream sees only the latched request; read data is shared and qualified by rsp_valid_o
  assign mem_req_rw_o     = rw_q;
  assign mem_req_byteen_o = byteen_q;
  assign mem_req_addr_o   = addr_q;
  assign mem_req_data_o   = data_q;
  assign mem_req_tag_o    = tag_q;
  assign rsp_data_o       = mem_rsp_data_i;
  assign rsp_tag_o        = mem_rsp_tag_i;
  assign err_o            = err_q;

  // Next-state, capture and handshake outputs for the grant/send/response sequence
  always_comb begin
    state_d         = state_q;
    prio_ptr_d      = prio_ptr_q;
    owner_d         = owner_q;
    rw_d            = rw_q;
    byteen_d        = byteen_q;
    addr_d          = addr_q;
    data_d          = data_q;
    tag_d           = tag_q;
    err_d           = err_q;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready_o = pick_grant;
          owner_d     = pick_idx;
          rw_d        = req_rw_i[pick_idx];
          byteen_d    = req_byteen_i[int'(pick_idx)*BE_W +: BE_W];
          addr_d      = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
          data_d      = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
          tag_d       = req_tag_i[int'(pick_idx)*TAG_WIDTH_BIT +: TAG_WIDTH_BIT];
          prio_ptr_d  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = rw_q ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        rsp_valid_o[owner_q] = mem_rsp_valid_i;
        mem_rsp_ready_o      = rsp_ready_i[owner_q];
        if (mem_rsp_valid_i && rsp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A response with nothing outstanding is dropped and flagged until reset
    if (mem_rsp_valid_i && (state_q != WAIT_RSP)) begin
      err_d = 1'b1;
    end
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
      rw_q       <= 1'b0;
      byteen_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      byteen_q   <= byteen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_vx_mem_obi_arbiter.sv
// tb/tb_vx_mem_obi_arbiter.sv - scoreboard bench for the VX memory port arbiter
module tb_vx_mem_obi_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TW      = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*4-1:0]    req_byteen;
  logic [NUM_REQ*32-1:0]   req_addr, req_data;
  logic [NUM_REQ*TW-1:0]   req_tag;
  logic [31:0]             rsp_data;
  logic [TW-1:0]           rsp_tag;
  logic                    mem_req_valid, mem_req_rw, mem_req_ready;
  logic [3:0]              mem_req_byteen;
  logic [31:0]             mem_req_addr, mem_req_data;
  logic [TW-1:0]           mem_req_tag;
  logic                    mem_rsp_valid, mem_rsp_ready, err;
  logic [31:0]             mem_rsp_data;
  logic [TW-1:0]           mem_rsp_tag;

  always #5 clk = ~clk;

  vx_mem_obi_arbiter #(.NUM_REQ(NUM_REQ), .TAG_WIDTH_BIT(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_rw_i(req_rw), .req_byteen_i(req_byteen),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_tag_i(req_tag),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .rsp_ready_i(rsp_ready),
    .mem_req_valid_o(mem_req_valid), .mem_req_rw_o(mem_req_rw),
    .mem_req_byteen_o(mem_req_byteen), .mem_req_addr_o(mem_req_addr),
    .mem_req_data_o(mem_req_data), .mem_req_tag_o(mem_req_tag),
    .mem_req_ready_i(mem_req_ready), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_tag_i(mem_rsp_tag),
    .mem_rsp_ready_o(mem_rsp_ready), .err_o(err)
  );

  typedef struct {
    logic          rw;
    logic [3:0]    be;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [TW-1:0] tag;
  } mreq_t;

  typedef struct {
    logic [NUM_REQ-1:0] vld;
    logic [31:0]        data;
    logic [TW-1:0]      tag;
  } mrsp_t;

  mreq_t exp_req_q[$];
  mrsp_t exp_rsp_q[$];
  int    exp_grant_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0;
    req_tag = '0; rsp_ready = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_tag = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step(); step();
    rst = 1'b0;
    #1;
    total_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid got %0b want 0", mem_req_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else pass_cnt++;
    total_cnt++; if (mem_rsp_ready !== 1'b0) $display("FAIL reset_mem_rsp_ready got %0b want 0", mem_rsp_ready); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else pass_cnt++;
    total_cnt++; if ({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data} !== '0)
      $display("FAIL reset_latched got %h/%h/%h want 0", mem_req_byteen, mem_req_addr, mem_req_data); else pass_cnt++;
  endtask

  task automatic test_single_read();
    mreq_t e;
    mrsp_t r;
    req_valid = 2'b01; req_rw[0] = 1'b0; req_byteen[3:0] = 4'hF;
    req_addr[31:0] = 32'h100; req_data[31:0] = 32'h0; req_tag[0] = 1'b1; rsp_ready = 2'b11;
    exp_req_q.push_back('{1'b0, 4'hF, 32'h100, 32'h0, 1'b1});
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL read_grant got %b want 01", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00;
    #1;
    total_cnt++; if (mem_req_valid !== 1'b1) $display("FAIL read_mem_req_valid got %0b want 1", mem_req_valid); else pass_cnt++;
    e = exp_req_q.pop_front();
    total_cnt++; if ({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_tag} !== {e.rw, e.be, e.addr, e.tag})
      $display("FAIL read_fields got rw%0b be%h a%h t%h want rw%0b be%h a%h t%h", mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_tag, e.rw, e.be, e.addr, e.tag); else pass_cnt++;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    total_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL read_req_dropped got %0b want 0", mem_req_valid); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL read_no_early_rsp got %b want 00", rsp_valid); else pass_cnt++;
      step();
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; mem_rsp_tag = 1'b1;
    exp_rsp_q.push_back('{2'b01, 32'hDEADBEEF, 1'b1});
    #1;
    r = exp_rsp_q.pop_front();
    total_cnt++; if (rsp_valid !== r.vld) $display("FAIL read_rsp_valid got %b want %b", rsp_valid, r.vld); else pass_cnt++;
    total_cnt++; if ({rsp_data, rsp_tag} !== {r.data, r.tag}) $display("FAIL read_rsp_data got %h/%h want %h/%h", rsp_data, rsp_tag, r.data, r.tag); else pass_cnt++;
    total_cnt++; if (mem_rsp_ready !== 1'b1) $display("FAIL read_mem_rsp_ready got %0b want 1", mem_rsp_ready); else pass_cnt++;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL read_rsp_done got %b want 00", rsp_valid); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL read_err got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_contention();
    int g;
    rst = 1'b1;
    clear_inputs();
    step(); step();
    rst = 1'b0;
    req_valid = 2'b11; req_rw = 2'b11; req_byteen = 8'hFF;
    req_addr = {32'h2000, 32'h1000}; req_data = {32'hB, 32'hA}; mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) exp_grant_q.push_back(k % 2);
    for (int k = 0; k < 6; k++) begin
      g = exp_grant_q.pop_front();
      #1;
      total_cnt++; if (req_ready !== (2'b01 << g)) $display("FAIL contention_grant%0d got %b want %b", k, req_ready, 2'b01 << g); else pass_cnt++;
      step();
      #1;
      total_cnt++; if (!mem_req_valid || mem_req_addr !== (g == 1 ? 32'h2000 : 32'h1000))
        $display("FAIL contention_addr%0d got v%0b %h want v1 %h", k, mem_req_valid, mem_req_addr, (g == 1 ? 32'h2000 : 32'h1000)); else pass_cnt++;
      if (k == 5) req_valid = 2'b00;
      step();
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_write();
    mreq_t e;
    req_valid = 2'b10; req_rw[1] = 1'b1; req_byteen[7:4] = 4'hF;
    req_addr[63:32] = 32'h40; req_data[63:32] = 32'h12345678; req_tag[1] = 1'b0;
    exp_req_q.push_back('{1'b1, 4'hF, 32'h40, 32'h12345678, 1'b0});
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL write_grant got %b want 10", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00;
    #1;
    e = exp_req_q.pop_front();
    total_cnt++; if ({mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} !== {1'b1, e.rw, e.be, e.addr, e.data, e.tag})
      $display("FAIL write_fields got v%0b rw%0b be%h a%h d%h t%h want v1 rw%0b be%h a%h d%h t%h", mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag, e.rw, e.be, e.addr, e.data, e.tag); else pass_cnt++;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    total_cnt++; if ({mem_req_valid, rsp_valid} !== 3'b000) $display("FAIL write_done got v%0b rsp%b want 0 00", mem_req_valid, rsp_valid); else pass_cnt++;
    req_valid = 2'b01; req_rw[0] = 1'b1; req_addr[31:0] = 32'h80;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL write_back_to_idle got %b want 01", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00; mem_req_ready = 1'b1;
    #1;
    total_cnt++; if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, 1'b1, 32'h80}) $display("FAIL write2_fields got %0b %0b %h want 1 1 80", mem_req_valid, mem_req_rw, mem_req_addr); else pass_cnt++;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    mreq_t e;
    mrsp_t r;
    req_valid = 2'b11; req_rw = 2'b01; req_byteen = 8'h3F;
    req_addr = {32'h200, 32'h300}; req_data = {32'h0, 32'h55}; req_tag = 2'b10; rsp_ready = 2'b11;
    exp_req_q.push_back('{1'b0, 4'h3, 32'h200, 32'h0, 1'b1});
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL bp_grant got %b want 10", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b01;
    e = exp_req_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_tag, req_ready} !== {1'b1, e.rw, e.be, e.addr, e.tag, 2'b00})
        $display("FAIL bp_req_stable%0d got v%0b rw%0b be%h a%h t%h rdy%b", i, mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_tag, req_ready); else pass_cnt++;
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D; mem_rsp_tag = 1'b1; rsp_ready = 2'b01;
    exp_rsp_q.push_back('{2'b10, 32'hCAFEF00D, 1'b1});
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if ({rsp_valid, mem_rsp_ready, req_ready} !== {2'b10, 1'b0, 2'b00})
        $display("FAIL bp_rsp_stall%0d got rsp%b mrdy%0b rdy%b want 10 0 00", i, rsp_valid, mem_rsp_ready, req_ready); else pass_cnt++;
      step();
    end
    rsp_ready = 2'b11;
    #1;
    r = exp_rsp_q.pop_front();
    total_cnt++; if ({rsp_valid, rsp_data, rsp_tag, mem_rsp_ready} !== {r.vld, r.data, r.tag, 1'b1})
      $display("FAIL bp_rsp got %b %h %h %0b want %b %h %h 1", rsp_valid, rsp_data, rsp_tag, mem_rsp_ready, r.vld, r.data, r.tag); else pass_cnt++;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL bp_next_grant got %b want 01", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00; mem_req_ready = 1'b1;
    #1;
    total_cnt++; if ({mem_req_rw, mem_req_addr, mem_req_data} !== {1'b1, 32'h300, 32'h55}) $display("FAIL bp_r0_write got %0b %h %h want 1 300 55", mem_req_rw, mem_req_addr, mem_req_data); else pass_cnt++;
    step();
    mem_req_ready = 1'b0;
    #1;
    total_cnt++; if (err !== 1'b0) $display("FAIL bp_err got %0b want 0", err); else pass_cnt++;
  endtask

  task automatic test_error_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD0BAD;
    #1;
    total_cnt++; if ({mem_rsp_ready, rsp_valid, err} !== 4'b0000) $display("FAIL err_drop got mrdy%0b rsp%b err%0b want 0 00 0", mem_rsp_ready, rsp_valid, err); else pass_cnt++;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    total_cnt++; if (err !== 1'b1) $display("FAIL err_set got %0b want 1", err); else pass_cnt++;
    step(); step(); step();
    #1;
    total_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got %0b want 1", err); else pass_cnt++;
    req_valid = 2'b10; req_rw = 2'b00; rsp_ready = 2'b11;
    step();
    req_valid = 2'b00; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    total_cnt++; if (mem_rsp_ready !== 1'b1) $display("FAIL err_in_wait got %0b want 1", mem_rsp_ready); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total_cnt++; if ({err, mem_req_valid, mem_rsp_ready} !== 3'b000) $display("FAIL err_after_reset got err%0b v%0b mrdy%0b want 000", err, mem_req_valid, mem_rsp_ready); else pass_cnt++;
    req_valid = 2'b11; req_rw = 2'b11;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL err_reset_grant got %b want 01", req_ready); else pass_cnt++;
    step();
    req_valid = 2'b00; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_backpressure();
    test_error_reset();
    total_cnt++;
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0 || exp_grant_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d/%0d/%0d want 0/0/0", exp_req_q.size(), exp_rsp_q.size(), exp_grant_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
